// File: rtl/lcd_string_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_string_writer: streams a prefix command plus message characters to the |
// | LCD controller over its E/DATA handshake.        Revision: 1.0             |
// +----------------------------------------------------------------------------+
module lcd_string_writer #(
   parameter int         MAX_LEN     = 32,
   parameter int         LINE_LEN    = 16,
   parameter logic [7:0] LINE2_CMD   = 8'hC0,
   parameter logic [7:0] HOME_CMD    = 8'h80,
   parameter logic [7:0] CLEAR_CMD   = 8'h01,
   parameter int         ACK_TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [8*MAX_LEN-1:0]         msg,
   input  logic [$clog2(MAX_LEN+1)-1:0] len,
   input  logic                         clear_first,
   input  logic                         lcd_ready,
   output logic [7:0]                   lcd_data,
   output logic                         lcd_rs,
   output logic                         lcd_e,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [3:0]                   state_dbg
);

   localparam int LW = $clog2(MAX_LEN+1);
   localparam int CW = $clog2(ACK_TIMEOUT+1);
   localparam logic [LW-1:0] MAX_POS  = LW'(MAX_LEN);
   localparam logic [LW-1:0] LINE_POS = LW'(LINE_LEN);
   localparam logic [CW-1:0] TMO      = CW'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_ACK   = 3'd2,
      WAIT_READY = 3'd3,
      DONE       = 3'd4
   } state_t;

   state_t               state, state_nx;
   logic [8*MAX_LEN-1:0] msg_q;
   logic [LW-1:0]        len_q, char_idx, char_idx_nx;
   logic                 clear_q, at_prefix, at_prefix_nx, wrap_done, wrap_done_nx;
   logic [CW-1:0]        tmo_cnt, tmo_cnt_nx;
   logic [7:0]           data_nx, cur_char, item_data;
   logic                 rs_nx, e_nx, busy_nx, err_nx, latch;
   logic                 wrap_item, last_item, item_rs;

   // The line-2 address is slotted in once, just before char LINE_LEN.
   assign wrap_item = !at_prefix && !wrap_done && (len_q > LINE_POS) && (char_idx == LINE_POS);
   assign last_item = at_prefix ? (len_q == '0)
                                : (!wrap_item && (char_idx == len_q - LW'(1)));
   assign cur_char  = 8'(msg_q >> {char_idx, 3'b000});
   assign item_rs   = !at_prefix && !wrap_item;
   assign item_data = at_prefix ? (clear_q ? CLEAR_CMD : HOME_CMD)
                                : (wrap_item ? LINE2_CMD : cur_char);
   assign state_dbg = 4'(state);

   always_comb begin
      state_nx     = state;
      at_prefix_nx = at_prefix;
      wrap_done_nx = wrap_done;
      char_idx_nx  = char_idx;
      tmo_cnt_nx   = tmo_cnt;
      data_nx      = lcd_data;
      rs_nx        = lcd_rs;
      e_nx         = 1'b0;
      busy_nx      = busy;
      err_nx       = err;
      latch        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               latch        = 1'b1;
               err_nx       = 1'b0;
               busy_nx      = 1'b1;
               at_prefix_nx = 1'b1;
               wrap_done_nx = 1'b0;
               char_idx_nx  = '0;
               state_nx     = ISSUE;
            end
         end
         ISSUE: begin
            if (lcd_ready) begin
               data_nx    = item_data;
               rs_nx      = item_rs;
               e_nx       = 1'b1;
               tmo_cnt_nx = '0;
               state_nx   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!lcd_ready) begin
               state_nx = WAIT_READY;
            end else begin
               tmo_cnt_nx = tmo_cnt + CW'(1);
               if (tmo_cnt_nx == TMO) begin
                  err_nx   = 1'b1;
                  state_nx = DONE;
               end
            end
         end
         WAIT_READY: begin
            // No timeout here: a clear-display can keep the controller busy ~44k cycles.
            if (lcd_ready) begin
               if (last_item) begin
                  state_nx = DONE;
               end else begin
                  state_nx = ISSUE;
                  if (at_prefix)      at_prefix_nx = 1'b0;
                  else if (wrap_item) wrap_done_nx = 1'b1;
                  else                char_idx_nx  = char_idx + LW'(1);
               end
            end
         end
         DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         at_prefix <= 1'b1;
         wrap_done <= 1'b0;
         char_idx  <= '0;
         tmo_cnt   <= '0;
         len_q     <= '0;
         clear_q   <= 1'b0;
         lcd_data  <= 8'h00;
         lcd_rs    <= 1'b0;
         lcd_e     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         at_prefix <= at_prefix_nx;
         wrap_done <= wrap_done_nx;
         char_idx  <= char_idx_nx;
         tmo_cnt   <= tmo_cnt_nx;
         lcd_data  <= data_nx;
         lcd_rs    <= rs_nx;
         lcd_e     <= e_nx;
         busy      <= busy_nx;
         done      <= (state_nx == DONE);
         err       <= err_nx;
         if (latch) begin
            len_q   <= (len > MAX_POS) ? MAX_POS : len;
            clear_q <= clear_first;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (latch) msg_q <= msg;
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_string_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_string_writer: directed and random messages against a queue model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lcd_string_writer;

   localparam int MAX_LEN     = 32;
   localparam int LW          = $clog2(MAX_LEN+1);
   localparam int MW          = 8*MAX_LEN;
   localparam int LINE_LEN    = 16;
   localparam int ACK_TIMEOUT = 64;
   localparam int BUDGET      = 3000;

   logic          clk = 1'b0;
   logic          rst, start, clear_first, lcd_ready;
   logic [MW-1:0] msg;
   logic [LW-1:0] len;
   logic [7:0]    lcd_data;
   logic          lcd_rs, lcd_e, busy, done, err;
   logic [3:0]    state_dbg;

   int n_cmp = 0;
   int n_bad = 0;
   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];
   int first_e_cyc, last_e_cyc, done_cyc, done_cnt, double_e, pulses;

   always #5 clk = ~clk;

   lcd_string_writer #(
      .MAX_LEN(MAX_LEN), .LINE_LEN(LINE_LEN), .LINE2_CMD(8'hC0),
      .HOME_CMD(8'h80), .CLEAR_CMD(8'h01), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .msg(msg), .len(len),
      .clear_first(clear_first), .lcd_ready(lcd_ready), .lcd_data(lcd_data),
      .lcd_rs(lcd_rs), .lcd_e(lcd_e), .busy(busy), .done(done), .err(err),
      .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected pulse list: prefix, chars, with line-2 address before char LINE_LEN.
   function automatic void build_exp(input logic [MW-1:0] m, input int l, input logic cf);
      int n;
      n = (l > MAX_LEN) ? MAX_LEN : l;
      exp_q.delete();
      exp_q.push_back({1'b0, (cf ? 8'h01 : 8'h80)});
      for (int i = 0; i < n; i++) begin
         if (i == LINE_LEN && n > LINE_LEN) exp_q.push_back({1'b0, 8'hC0});
         exp_q.push_back({1'b1, m[8*i +: 8]});
      end
   endfunction

   task automatic compare_obs(input string tag, input int n_exp);
      int n;
      check({tag, "_count"}, 32'(obs_q.size()), 32'(n_exp));
      n = (obs_q.size() < n_exp) ? obs_q.size() : n_exp;
      for (int i = 0; i < n; i++)
         check($sformatf("%s_pulse%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
   endtask

   task automatic run_msg(input logic [MW-1:0] m, input int l, input logic cf,
                          input int stuck_after, input bit disturb, input int rst_after,
                          output bit did_rst);
      int hold, cyc;
      bit prev_e, fin, poked;
      obs_q.delete();
      first_e_cyc = -1; last_e_cyc = -1; done_cyc = -1;
      done_cnt = 0; double_e = 0; pulses = 0;
      did_rst = 0; hold = 0; prev_e = 0; fin = 0; poked = 0; cyc = 0;
      @(negedge clk);
      lcd_ready = 1'b1; msg = m; len = LW'(l); clear_first = cf; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      msg = {8{$urandom}}; len = LW'($urandom); clear_first = ~cf;
      check("busy_after_start", 32'(busy), 32'd1);
      check("err_clear_on_start", 32'(err), 32'd0);
      while (!fin && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (start) start = 1'b0;
         else if (disturb && pulses == 2 && !poked) begin
            start = 1'b1; poked = 1;
            msg = {8{$urandom}}; len = LW'($urandom_range(1, 40));
         end
         if (lcd_e) begin
            obs_q.push_back({lcd_rs, lcd_data});
            pulses++;
            if (prev_e) double_e++;
            if (first_e_cyc < 0) first_e_cyc = cyc;
            last_e_cyc = cyc;
            if (stuck_after > 0 && pulses >= stuck_after) lcd_ready = 1'b1;
            else begin lcd_ready = 1'b0; hold = $urandom_range(1, 6); end
         end else if (hold > 0) begin
            if (rst_after > 0 && pulses == rst_after) begin
               check("state_before_rst", 32'(state_dbg), 32'd3);
               rst = 1'b1; did_rst = 1; fin = 1;
            end else begin
               hold--;
               if (hold == 0) lcd_ready = 1'b1;
            end
         end
         prev_e = lcd_e;
         if (done && !did_rst) begin done_cnt++; done_cyc = cyc; fin = 1; end
      end
      check("run_finished", 32'(fin), 32'd1);
      start = 1'b0;
      if (!did_rst) begin
         check("no_back_to_back_e", 32'(double_e), 32'd0);
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
         check("busy_low_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      logic [MW-1:0] m;
      string s;
      bit r;
      int l, n_e;
      rst = 1'b1; start = 1'b0; msg = '0; len = '0; clear_first = 1'b0; lcd_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_lcd_data", 32'(lcd_data), 32'd0);
      check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
      check("rst_lcd_e", 32'(lcd_e), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst = 1'b0;

      m = '0; s = "HELLO WILL";
      for (int i = 0; i < s.len(); i++) m[8*i +: 8] = s[i];
      build_exp(m, 10, 1'b1);
      run_msg(m, 10, 1'b1, 0, 1'b0, 0, r);
      compare_obs("hello", exp_q.size());
      check("hello_first_e_latency", 32'(first_e_cyc), 32'd1);
      check("hello_done_count", 32'(done_cnt), 32'd1);
      check("hello_err", 32'(err), 32'd0);

      m = '0;
      for (int i = 0; i < 20; i++) m[8*i +: 8] = 8'(8'h41 + i);
      build_exp(m, 20, 1'b0);
      run_msg(m, 20, 1'b0, 0, 1'b1, 0, r);
      compare_obs("wrap_restart", exp_q.size());

      build_exp(m, 0, 1'b0);
      run_msg(m, 0, 1'b0, 0, 1'b0, 0, r);
      compare_obs("len0", exp_q.size());
      check("len0_done_count", 32'(done_cnt), 32'd1);

      for (int i = 0; i < MAX_LEN; i++) m[8*i +: 8] = 8'($urandom_range(32, 126));
      build_exp(m, 40, 1'b1);
      run_msg(m, 40, 1'b1, 0, 1'b0, 0, r);
      compare_obs("clamp40", 34);

      build_exp(m, 10, 1'b1);
      run_msg(m, 10, 1'b1, 3, 1'b0, 0, r);
      compare_obs("timeout", 3);
      check("timeout_err", 32'(err), 32'd1);
      check("timeout_latency", 32'(done_cyc - last_e_cyc), 32'(ACK_TIMEOUT));
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);

      build_exp(m, 12, 1'b0);
      run_msg(m, 12, 1'b0, 0, 1'b0, 4, r);
      check("rst_taken", 32'(r), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_lcd_data", 32'(lcd_data), 32'd0);
      check("midrst_lcd_rs", 32'(lcd_rs), 32'd0);
      check("midrst_lcd_e", 32'(lcd_e), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_state", 32'(state_dbg), 32'd0);
      n_e = 0;
      for (int c = 0; c < 40; c++) begin
         lcd_ready = 1'($urandom);
         @(negedge clk);
         if (lcd_e) n_e++;
      end
      check("no_e_after_rst", 32'(n_e), 32'd0);

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < MAX_LEN; i++) m[8*i +: 8] = 8'($urandom_range(32, 126));
         l = $urandom_range(0, 40);
         build_exp(m, l, 1'($urandom));
         run_msg(m, l, exp_q[0] == 9'h001, 0, 1'($urandom), 0, r);
         compare_obs($sformatf("rand%0d", t), exp_q.size());
         check($sformatf("rand%0d_err", t), 32'(err), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
